transmitter_i2c: RTL and testbench
==================================

// Module: transmitter_i2c
// PURPOSE
//  I2C master (transmitter) for one 16-bit transaction per request: START, 7-bit address + R/W, two data bytes, STOP.
//  Directly upstream of the I2C slave receiver: drives its SCL, SDA_OUT and SDA_OE inputs and samples its SDA_IN reply.
//  Request side is a CPU-facing strobe/parallel interface.
// PARAMETERS
//  SCL_DIV  4  clk cycles per SCL period; multiple of 4, >=4. H = SCL_DIV/2, Q = SCL_DIV/4.
// PORTS
//  clk       in   1   single system clock; all logic on posedge.
//  rst       in   1   synchronous reset, active-high.
//  START_STB in   1   one-cycle request; accepted only in IDLE.
//  RNW       in   1   latched with START_STB: 1 = read from slave, 0 = write to slave.
//  I2C_ADDR  in   7   slave address, latched with START_STB.
//  WR_DATA   in   16  write payload, latched with START_STB; [15:8] sent first, MSB first.
//  SDA_IN    in   1   SDA driven by slave (ACK and read bits).
//  SCL       out  1   I2C clock; reset 1.
//  SDA_OUT   out  1   SDA value driven by master; reset 1.
//  SDA_OE    out  1   1 = master owns SDA, 0 = slave owns SDA; reset 1.
//  RD_DATA   out  16  read payload, updated only at end of read transaction; reset 0.
//  BUSY      out  1   high from cycle after accepted START_STB through DONE cycle; reset 0.
//  DONE      out  1   one-cycle pulse on transaction end, normal or aborted; reset 0.
//  NACK_ERR  out  1   set when slave ACK slot samples 1; cleared on next accepted START_STB; reset 0.
// BEHAVIOUR
//  - FSM: IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP. Free phase counter 0..SCL_DIV-1, reset to 0 on leaving IDLE.
//  - Bit slot = SCL_DIV cycles: SCL=0 for phases 0..H-1, SCL=1 for H..SCL_DIV-1.
//    Master SDA_OUT/SDA_OE change only at phase Q.
//    SDA_IN sampled on the cycle SCL goes 0->1 (phase H).
//  - IDLE: SCL=1, SDA_OUT=1, SDA_OE=1. START_STB latches RNW/I2C_ADDR/WR_DATA and sets BUSY next cycle.
//    START_STB while BUSY is ignored and causes no state change.
//  - START: SCL=1, SDA_OUT drops 1->0 for H cycles, then SCL falls and ADDR begins.
//  - ADDR: 8 slots, {I2C_ADDR, RNW} MSB first, SDA_OE=1.
//  - ADDR_ACK: 1 slot, SDA_OE=0; sampled SDA_IN=1 sets NACK_ERR.
//  - Write path:
//    - WR_BYTE: 8 slots, SDA_OE=1.
//    - WR_ACK: 1 slot, SDA_OE=0.
//    - Runs twice (byte [15:8], then [7:0]), then STOP.
//  - Read path:
//    - RD_BYTE: 8 slots, SDA_OE=0, shift SDA_IN MSB first into an internal register.
//    - RD_ACK: SDA_OE=1. After byte 1, drive ACK (SDA_OUT=0). After byte 2, drive NACK (SDA_OUT=1).
//    - RD_DATA loads the full 16 bits in the STOP entry cycle.
//  - STOP: SDA_OE=1. SDA_OUT=0 at phase Q with SCL low, SCL rises at H, SDA_OUT rises at H+Q. Then DONE=1 for one cycle, BUSY=0 and IDLE the next cycle.
//  - Length: 1 START + 27 slots + 1 STOP. Not counting NACK abort, DONE occurs exactly (1 + 27 + 1) * SCL_DIV cycles after BUSY rises (H of START padded to full slot).
//  - rst mid-transaction: all outputs take reset values on that edge, FSM to IDLE, no DONE, latched request discarded.
//  - NACK on a data ACK slot sets NACK_ERR only; the transaction completes.
// CONFIGURATION
//  - I2C_NACK_ABORT_EN defined: NACK in ADDR_ACK jumps straight to STOP (no data slots). DONE and NACK_ERR both asserted, RD_DATA unchanged.
//  - Undefined: NACK in ADDR_ACK sets NACK_ERR and the full transaction still runs (default).
// TESTING
//  - Write: ADDR=0x2A, RNW=0, WR_DATA=0xBEEF, slave ACKs all. SDA at SCL rises = 0x54,ack,0xBE,ack,0xEF,ack. DONE after 29*SCL_DIV cycles, NACK_ERR=0.
//  - Read: ADDR=0x15, RNW=1, slave returns 0xC3 then 0xA5. RD_DATA=0xC3A5 at DONE, master ACK slot SDA=0 then 1, SDA_OE=0 during data bits.
//  - Address NACK: SDA_IN=1 in ADDR_ACK. NACK_ERR=1. With I2C_NACK_ABORT_EN, DONE at (1+9+1)*SCL_DIV cycles. Without it, DONE at 29*SCL_DIV cycles.
//  - START_STB pulsed mid-transaction with ADDR=0x7F: ignored, bus pattern and latched data unchanged, single DONE.
//  - rst=1 during WR_BYTE: next cycle SCL=1, SDA_OUT=1, SDA_OE=1, BUSY=0, no DONE. A new request afterwards completes normally.
//  - SCL_DIV=8: SCL high/low exactly 4 cycles each, SDA never changes while SCL=1 except START/STOP edges (checked by assertion).

Source files
------------

// File: rtl/transmitter_i2c.sv
// -----------------------------------------------------------------------------
// transmitter_i2c
//
// I2C master that runs one 16-bit transaction per request:
//   START, 7-bit address + R/W, ACK, two data bytes each followed by an ACK
//   slot, STOP.
// Writes send WR_DATA[15:8] first, MSB first, and sample the slave's ACKs.
// Reads shift in two bytes from the slave. The master answers ACK after the
// first byte and NACK after the second. RD_DATA updates as STOP begins.
//
// Every bit slot is SCL_DIV clocks long:
//   - SCL is low for phases 0..H-1 and high for phases H..SCL_DIV-1.
//   - SDA_OUT and SDA_OE change only at phase Q.
//   - SDA_IN is sampled in the phase-H cycle, the first cycle with SCL high.
//
// Optional build macro:
//   I2C_NACK_ABORT_EN - a NACK in the address ACK slot jumps straight to
//                       STOP and skips the data slots. When the macro is
//                       undefined, the full transaction runs anyway.
//
// Parameters:
//   SCL_DIV   clk cycles per SCL period. Must be a multiple of 4 and >= 4.
//             H = SCL_DIV/2, Q = SCL_DIV/4.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   START_STB  one-cycle request strobe, accepted only while idle
//   RNW        1 = read from slave, 0 = write to slave (latched on accept)
//   I2C_ADDR   7-bit slave address (latched on accept)
//   WR_DATA    16-bit write payload (latched on accept)
//   SDA_IN     SDA as driven by the slave
//   SCL        I2C clock (idles high)
//   SDA_OUT    SDA value driven by the master (idles high)
//   SDA_OE     1 = master owns SDA, 0 = slave owns SDA
//   RD_DATA    16-bit read payload
//   BUSY       high from the cycle after an accepted request through DONE
//   DONE       one-cycle pulse at the end of every transaction
//   NACK_ERR   a slave ACK slot sampled 1; cleared on the next accepted request
// -----------------------------------------------------------------------------
module transmitter_i2c #(
  parameter int SCL_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        START_STB,
  input  logic        RNW,
  input  logic [6:0]  I2C_ADDR,
  input  logic [15:0] WR_DATA,
  input  logic        SDA_IN,
  output logic        SCL,
  output logic        SDA_OUT,
  output logic        SDA_OE,
  output logic [15:0] RD_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        NACK_ERR
);

  localparam int PH_W = $clog2(SCL_DIV);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_Q    = PH_W'(SCL_DIV / 4);
  localparam logic [PH_W-1:0] PH_H    = PH_W'(SCL_DIV / 2);
  localparam logic [PH_W-1:0] PH_HQ   = PH_W'(SCL_DIV / 2 + SCL_DIV / 4);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCL_DIV - 1);

`ifdef I2C_NACK_ABORT_EN
  localparam logic NACK_ABORT = 1'b1;
`else
  localparam logic NACK_ABORT = 1'b0;
`endif

  // ST_DONE is the single cycle that carries the DONE pulse. BUSY is still
  // high in that cycle, so a request arriving then is ignored.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START    = 4'd1;
  localparam logic [3:0] ST_ADDR     = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK = 4'd3;
  localparam logic [3:0] ST_WR_BYTE  = 4'd4;
  localparam logic [3:0] ST_WR_ACK   = 4'd5;
  localparam logic [3:0] ST_RD_BYTE  = 4'd6;
  localparam logic [3:0] ST_RD_ACK   = 4'd7;
  localparam logic [3:0] ST_STOP     = 4'd8;
  localparam logic [3:0] ST_DONE     = 4'd9;

  logic [3:0]      state_q,    state_d;
  logic [PH_W-1:0] phase_q,    phase_d;
  logic [2:0]      bit_cnt_q,  bit_cnt_d;
  logic            byte_cnt_q, byte_cnt_d;
  logic [6:0]      addr_q,     addr_d;
  logic            rnw_q,      rnw_d;
  logic [15:0]     wr_data_q,  wr_data_d;
  logic [15:0]     rd_shift_q, rd_shift_d;
  logic [15:0]     rd_data_q,  rd_data_d;
  logic            sda_smp_q,  sda_smp_d;
  logic            nack_q,     nack_d;
  logic            scl_q,      scl_d;
  logic            sda_q,      sda_d;
  logic            oe_q,       oe_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;

  logic       slot_end;
  logic       at_h;
  logic       accept;
  logic [7:0] addr_byte;

  assign slot_end  = (phase_q == PH_LAST);
  assign at_h      = (phase_q == PH_H);
  assign accept    = (state_q == ST_IDLE) && START_STB;
  assign addr_byte = {addr_q, rnw_q};

  // Next-state logic.
  // The bus outputs are decoded from the next state and next phase, and then
  // registered. This keeps them glitch-free and aligned with state_q and
  // phase_q. SDA holds its value between phase-Q updates. The only other
  // SDA change is the rising edge at phase H+Q of STOP.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    rnw_d      = rnw_q;
    wr_data_d  = wr_data_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
    sda_smp_d  = sda_smp_q;
    nack_d     = nack_q;
    sda_d      = sda_q;
    oe_d       = oe_q;
    scl_d      = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    if (state_q == ST_IDLE || state_q == ST_DONE || slot_end) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_ONE;
    end

    if (at_h && state_q != ST_IDLE) begin
      sda_smp_d = SDA_IN;
    end
    if (at_h && state_q == ST_RD_BYTE) begin
      rd_shift_d = {rd_shift_q[14:0], SDA_IN};
    end

    if (accept) begin
      nack_d = 1'b0;
    end else if (at_h && SDA_IN &&
                 (state_q == ST_ADDR_ACK || state_q == ST_WR_ACK)) begin
      nack_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (START_STB) begin
          state_d   = ST_START;
          addr_d    = I2C_ADDR;
          rnw_d     = RNW;
          wr_data_d = WR_DATA;
        end
      end
      ST_START: begin
        if (slot_end) begin
          state_d   = ST_ADDR;
          bit_cnt_d = 3'd0;
        end
      end
      ST_ADDR: begin
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_ADDR_ACK;
        end
      end
      ST_ADDR_ACK: begin
        if (slot_end) begin
          byte_cnt_d = 1'b0;
          if (NACK_ABORT && sda_smp_q) state_d = ST_STOP;
          else if (rnw_q)              state_d = ST_RD_BYTE;
          else                         state_d = ST_WR_BYTE;
        end
      end
      ST_WR_BYTE: begin
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_WR_ACK;
        end
      end
      ST_WR_ACK: begin
        if (slot_end) begin
          if (byte_cnt_q) begin
            state_d = ST_STOP;
          end else begin
            byte_cnt_d = 1'b1;
            state_d    = ST_WR_BYTE;
          end
        end
      end
      ST_RD_BYTE: begin
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
        end
      end
      ST_RD_ACK: begin
        if (slot_end) begin
          if (byte_cnt_q) begin
            state_d   = ST_STOP;
            rd_data_d = rd_shift_q;
          end else begin
            byte_cnt_d = 1'b1;
            state_d    = ST_RD_BYTE;
          end
        end
      end
      ST_STOP: begin
        if (slot_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    case (state_d)
      ST_IDLE, ST_START, ST_DONE: scl_d = 1'b1;
      default:                    scl_d = (phase_d >= PH_H);
    endcase

    if (state_d == ST_IDLE || state_d == ST_DONE) begin
      sda_d = 1'b1;
      oe_d  = 1'b1;
    end else if (phase_d == PH_Q) begin
      case (state_d)
        ST_START:   begin sda_d = 1'b0;                                oe_d = 1'b1; end
        ST_ADDR:    begin sda_d = addr_byte[~bit_cnt_d];               oe_d = 1'b1; end
        ST_WR_BYTE: begin sda_d = wr_data_q[{~byte_cnt_d, ~bit_cnt_d}]; oe_d = 1'b1; end
        ST_RD_ACK:  begin sda_d = byte_cnt_d;                          oe_d = 1'b1; end
        ST_STOP:    begin sda_d = 1'b0;                                oe_d = 1'b1; end
        default:    begin sda_d = 1'b1;                                oe_d = 1'b0; end
      endcase
    end else if (state_d == ST_STOP && phase_d == PH_HQ) begin
      sda_d = 1'b1;
    end
  end

  // State registers. Reset discards any request in flight and parks the bus
  // in its idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 1'b0;
      addr_q     <= 7'd0;
      rnw_q      <= 1'b0;
      wr_data_q  <= 16'd0;
      rd_shift_q <= 16'd0;
      rd_data_q  <= 16'd0;
      sda_smp_q  <= 1'b0;
      nack_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      oe_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      rnw_q      <= rnw_d;
      wr_data_q  <= wr_data_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      sda_smp_q  <= sda_smp_d;
      nack_q     <= nack_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SCL      = scl_q;
  assign SDA_OUT  = sda_q;
  assign SDA_OE   = oe_q;
  assign RD_DATA  = rd_data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign NACK_ERR = nack_q;

endmodule

// File: tb/tb_transmitter_i2c.sv
// -----------------------------------------------------------------------------
// tb_transmitter_i2c
//
// Drives transmitter_i2c with SCL_DIV=8 through a table of transactions and
// acts as a simple I2C slave. For every transaction, the expected line value
// and ownership at each SCL rise are queued when the request is issued. Each
// entry is popped and compared when the DUT raises SCL.
// -----------------------------------------------------------------------------
module tb_transmitter_i2c;

  localparam int D = 8;
  localparam int H = D / 2;

`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
  localparam logic [15:0] V4_RD = 16'hC3A5;
`else
  localparam bit ABORT = 1'b0;
  localparam logic [15:0] V4_RD = 16'h5A0F;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        START_STB;
  logic        RNW;
  logic [6:0]  I2C_ADDR;
  logic [15:0] WR_DATA;
  logic        SDA_IN;
  logic        SCL;
  logic        SDA_OUT;
  logic        SDA_OE;
  logic [15:0] RD_DATA;
  logic        BUSY;
  logic        DONE;
  logic        NACK_ERR;

  always #5 clk = ~clk;

  transmitter_i2c #(.SCL_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .START_STB (START_STB),
    .RNW       (RNW),
    .I2C_ADDR  (I2C_ADDR),
    .WR_DATA   (WR_DATA),
    .SDA_IN    (SDA_IN),
    .SCL       (SCL),
    .SDA_OUT   (SDA_OUT),
    .SDA_OE    (SDA_OE),
    .RD_DATA   (RD_DATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .NACK_ERR  (NACK_ERR)
  );

  // One transaction.
  //   ack[0]     slave reply in the address ACK slot (1 = NACK).
  //   ack[2:1]   slave replies in the two write ACK slots.
  //   sdata      bytes the slave returns on a read.
  //   mid        pulse a stray request part-way through the transaction.
  typedef struct {
    logic [6:0]  addr;
    logic        rnw;
    logic [15:0] wdata;
    logic [15:0] sdata;
    logic [2:0]  ack;
    logic        mid;
    logic        exp_nack;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[7];
  logic [1:0] expQ[$];
  logic       respQ[$];
  int checks = 0;
  int errors = 0;

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Compares one observed value with its expected value and reports a miss.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Queues one slot.
  //   {oe, b}  expected SDA owner and line value at the SCL rise.
  //   r        value the slave drives on SDA_IN while SCL is low.
  task automatic pushSlot(input logic oe, input logic b, input logic r);
    expQ.push_back({oe, b});
    respQ.push_back(r);
  endtask

  // Builds the expected slot sequence of a transaction from the I2C frame
  // format.
  task automatic buildExpected(input vec_t v);
    logic [7:0] ab;
    ab = {v.addr, v.rnw};
    expQ.delete();
    respQ.delete();
    for (int i = 7; i >= 0; i--) pushSlot(1'b1, ab[i], 1'b1);
    pushSlot(1'b0, v.ack[0], v.ack[0]);
    if (!(ABORT && v.ack[0])) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 7; i >= 0; i--) begin
          if (!v.rnw) pushSlot(1'b1, v.wdata[8*(1-b)+i], 1'b1);
          else        pushSlot(1'b0, v.sdata[8*(1-b)+i], v.sdata[8*(1-b)+i]);
        end
        if (!v.rnw) pushSlot(1'b0, v.ack[b+1], v.ack[b+1]);
        else        pushSlot(1'b1, (b == 1), 1'b1);
      end
    end
    pushSlot(1'b1, 1'b0, 1'b1);
  endtask

  // Issues one request and plays the slave until DONE. Along the way it checks
  // slot contents, SCL half-period lengths, SDA stability while SCL is high,
  // and the DONE timing and result outputs.
  task automatic applyStimulus(input vec_t v);
    int   n;
    int   cyc;
    int   riseCnt;
    int   lowLen;
    int   highLen;
    logic sclPrev;
    logic linePrev;
    logic line;
    logic [1:0] expSlot;
    bit   finished;

    buildExpected(v);
    n = expQ.size();
    @(negedge clk);
    START_STB = 1'b1;
    RNW       = v.rnw;
    I2C_ADDR  = v.addr;
    WR_DATA   = v.wdata;
    SDA_IN    = 1'b1;
    @(negedge clk);
    START_STB = 1'b0;
    RNW       = ~v.rnw;
    I2C_ADDR  = ~v.addr;
    WR_DATA   = ~v.wdata;
    checkOutput("busy_rise", BUSY, 1);
    checkOutput("nack_cleared", NACK_ERR, 0);

    cyc = 0; riseCnt = 0; lowLen = 0; highLen = 0;
    sclPrev = 1'b1; linePrev = 1'b1; finished = 1'b0;
    while (!finished && cyc <= (n + 1) * D + 20) begin
      line = SDA_OE ? SDA_OUT : SDA_IN;
      if (SCL && !sclPrev) begin
        checkOutput("scl_low_len", lowLen, H);
        if (expQ.size() == 0) begin
          checkOutput("extra_slot", riseCnt, n);
        end else begin
          expSlot = expQ.pop_front();
          checkOutput($sformatf("slot%0d_oe_sda", riseCnt), {SDA_OE, line}, expSlot);
        end
        riseCnt++;
      end
      if (!SCL && sclPrev && riseCnt > 0) checkOutput("scl_high_len", highLen, H);
      if (SCL && sclPrev && line !== linePrev) begin
        checks++;
        if (!((riseCnt == 0 && !line) || (riseCnt == n && line))) begin
          errors++;
          $display("[TB] FAIL sda_while_scl_high: actual=%0b required=%0b at slot %0d",
                   line, linePrev, riseCnt);
        end
      end
      if (SCL) begin
        if (!sclPrev) highLen = 0;
        highLen++;
      end else begin
        if (sclPrev) lowLen = 0;
        lowLen++;
      end
      sclPrev  = SCL;
      linePrev = line;
      if (!SCL) SDA_IN = (riseCnt < n) ? respQ[riseCnt] : 1'b1;

      if (v.mid && cyc == 5 * D) begin
        START_STB = 1'b1;
        I2C_ADDR  = 7'h7F;
        WR_DATA   = 16'h0000;
        RNW       = ~v.rnw;
      end else begin
        START_STB = 1'b0;
      end

      if (DONE) begin
        checkOutput("done_cycle", cyc, (n + 1) * D);
        checkOutput("rd_data", RD_DATA, v.exp_rd);
        checkOutput("nack_err", NACK_ERR, v.exp_nack);
        checkOutput("busy_at_done", BUSY, 1);
        checkOutput("slots_seen", riseCnt, n);
        finished = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end

    if (!finished) begin
      checkOutput("done_timeout", finished, 1);
    end else begin
      @(negedge clk);
      checkOutput("done_pulse", DONE, 0);
      checkOutput("busy_after", BUSY, 0);
      checkOutput("idle_bus", {SCL, SDA_OUT, SDA_OE}, 3'b111);
    end
    START_STB = 1'b0;
    SDA_IN    = 1'b1;
  endtask

  initial begin
    int doneSeen;

    rst = 1'b1; START_STB = 1'b0; RNW = 1'b0;
    I2C_ADDR = 7'd0; WR_DATA = 16'd0; SDA_IN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_bus", {SCL, SDA_OUT, SDA_OE, BUSY, DONE, NACK_ERR}, 6'b111000);
    checkOutput("reset_rd", RD_DATA, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", {SCL, SDA_OUT, SDA_OE, BUSY, DONE}, 5'b11100);

    vecs[0] = '{addr: 7'h2A, rnw: 1'b0, wdata: 16'hBEEF, sdata: 16'h0000, ack: 3'b000,
                mid: 1'b0, exp_nack: 1'b0, exp_rd: 16'h0000};
    vecs[1] = '{addr: 7'h15, rnw: 1'b1, wdata: 16'h0000, sdata: 16'hC3A5, ack: 3'b000,
                mid: 1'b0, exp_nack: 1'b0, exp_rd: 16'hC3A5};
    vecs[2] = '{addr: 7'h33, rnw: 1'b0, wdata: 16'h1234, sdata: 16'h0000, ack: 3'b001,
                mid: 1'b0, exp_nack: 1'b1, exp_rd: 16'hC3A5};
    vecs[3] = '{addr: 7'h40, rnw: 1'b0, wdata: 16'h00FF, sdata: 16'h0000, ack: 3'b100,
                mid: 1'b0, exp_nack: 1'b1, exp_rd: 16'hC3A5};
    vecs[4] = '{addr: 7'h7E, rnw: 1'b1, wdata: 16'h0000, sdata: 16'h5A0F, ack: 3'b001,
                mid: 1'b0, exp_nack: 1'b1, exp_rd: V4_RD};
    vecs[5] = '{addr: 7'h2A, rnw: 1'b0, wdata: 16'hBEEF, sdata: 16'h0000, ack: 3'b000,
                mid: 1'b1, exp_nack: 1'b0, exp_rd: V4_RD};
    vecs[6] = '{addr: 7'h01, rnw: 1'b1, wdata: 16'h0000, sdata: 16'h8001, ack: 3'b000,
                mid: 1'b0, exp_nack: 1'b0, exp_rd: 16'h8001};

    for (int i = 0; i < 7; i++) begin
      $display("[TB] transaction %0d addr=%0h rnw=%0b", i, vecs[i].addr, vecs[i].rnw);
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of the first write data byte, then a clean rerun.
    @(negedge clk);
    START_STB = 1'b1;
    RNW       = 1'b0;
    I2C_ADDR  = 7'h2A;
    WR_DATA   = 16'hBEEF;
    @(negedge clk);
    START_STB = 1'b0;
    SDA_IN    = 1'b0;
    repeat (13 * D) @(negedge clk);
    checkOutput("busy_before_rst", BUSY, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_bus", {SCL, SDA_OUT, SDA_OE, BUSY, DONE}, 5'b11100);
    checkOutput("mid_rst_rd", RD_DATA, 16'h0000);
    rst = 1'b0;
    doneSeen = 0;
    repeat (30 * D) begin
      @(negedge clk);
      if (DONE) doneSeen++;
    end
    checkOutput("no_done_after_rst", doneSeen, 0);
    checkOutput("idle_after_rst", {BUSY, SCL, SDA_OUT, SDA_OE}, 4'b0111);
    SDA_IN = 1'b1;
    applyStimulus(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
